// File: rtl/carregador_uart_pkg.sv
// Shared constants for the UART program loader: loader FSM encodings,
// receiver state encodings and the 8N1 frame definition.
package carregador_uart_pkg;

   localparam logic [2:0] ST_CONTA   = 3'd0;
   localparam logic [2:0] ST_DADOS   = 3'd1;
   localparam logic [2:0] ST_ESCRITA = 3'd2;
   localparam logic [2:0] ST_FIM     = 3'd3;
   localparam logic [2:0] ST_ERRO    = 3'd4;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   localparam int   FRAME_DATA_BITS = 8;
   localparam logic LINE_IDLE_LVL   = 1'b1;
   localparam logic FRAME_START_LVL = 1'b0;
   localparam logic FRAME_STOP_LVL  = 1'b1;

   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/carregador_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, half-bit start qualification and
// centre sampling of data and stop bits; one-cycle byte/frame-error pulses.
module carregador_uart_rx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic       byte_valid_o,
   output logic [7:0] dado_o,
   output logic       frame_err_o
);
   import carregador_uart_pkg::*;

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(FRAME_DATA_BITS - 1);

   logic          rxMeta_q, rxSync_q;
   logic [1:0]    rxState_q, rxState_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bitIdx_q, bitIdx_d;
   logic [7:0]    shift_q, shift_d;
   logic          byteValid_q, byteValid_d;
   logic          frameErr_q, frameErr_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxMeta_q <= LINE_IDLE_LVL;
         rxSync_q <= LINE_IDLE_LVL;
      end else begin
         rxMeta_q <= rx_i;
         rxSync_q <= rxMeta_q;
      end
   end

   always_comb begin
      rxState_d   = rxState_q;
      cnt_d       = cnt_q;
      bitIdx_d    = bitIdx_q;
      shift_d     = shift_q;
      byteValid_d = 1'b0;
      frameErr_d  = 1'b0;
      case (rxState_q)
         RX_IDLE: begin
            if (rxSync_q == FRAME_START_LVL) begin
               rxState_d = RX_START;
               cnt_d     = '0;
            end
         end
         RX_START: begin
            // A start edge that has gone high again by mid-bit is a glitch.
            if (cnt_q == HALF_LAST) begin
               cnt_d    = '0;
               bitIdx_d = '0;
               if (rxSync_q == FRAME_START_LVL) rxState_d = RX_DATA;
               else                             rxState_d = RX_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rxSync_q, shift_q[7:1]};
               if (bitIdx_q == LAST_BIT) rxState_d = RX_STOP;
               else                      bitIdx_d  = bitIdx_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            // Returning to idle at the stop-bit centre lets a back-to-back
            // start edge be caught at the end of this stop bit.
            if (cnt_q == BIT_LAST) begin
               cnt_d     = '0;
               rxState_d = RX_IDLE;
               if (rxSync_q == FRAME_STOP_LVL) byteValid_d = 1'b1;
               else                            frameErr_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: rxState_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxState_q   <= RX_IDLE;
         cnt_q       <= '0;
         bitIdx_q    <= '0;
         shift_q     <= '0;
         byteValid_q <= 1'b0;
         frameErr_q  <= 1'b0;
      end else begin
         rxState_q   <= rxState_d;
         cnt_q       <= cnt_d;
         bitIdx_q    <= bitIdx_d;
         shift_q     <= shift_d;
         byteValid_q <= byteValid_d;
         frameErr_q  <= frameErr_d;
      end
   end

   assign byte_valid_o = byteValid_q;
   assign frame_err_o  = frameErr_q;
   assign dado_o       = shift_q;

endmodule

// File: rtl/carregador_uart.sv
// Serial program loader: receives a word count and little-endian words over
// UART, writes them to instruction memory, then releases the core from reset.
module carregador_uart #(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 115200,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              uart_rx,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              carregado,
   output logic              erro
);
   import carregador_uart_pkg::*;

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int MAX_WORDS    = 1 << ADDR_W;

   logic       rxByteValid;
   logic       rxFrameErr;
   logic [7:0] rxDado;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] lastAddr_q, lastAddr_d;
   logic [1:0]        idx_q, idx_d;
   logic [31:0]       word_q, word_d;
   logic              imemWe_q, imemWe_d;
   logic              carregado_q, carregado_d;
   logic              erro_q, erro_d;
   logic              countBad;

   carregador_uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart_rx (
      .clk         (clk),
      .rst         (rst),
      .rx_i        (uart_rx),
      .byte_valid_o(rxByteValid),
      .dado_o      (rxDado),
      .frame_err_o (rxFrameErr)
   );

   assign countBad = (rxDado == 8'd0) || (int'(rxDado) > MAX_WORDS);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      lastAddr_d  = lastAddr_q;
      idx_d       = idx_q;
      word_d      = word_q;
      carregado_d = carregado_q;
      erro_d      = erro_q;
      case (state_q)
         ST_CONTA: begin
            if (rxFrameErr || (rxByteValid && countBad)) begin
               state_d = ST_ERRO;
               erro_d  = 1'b1;
            end else if (rxByteValid) begin
               // Keep N-1 so the final address compare fits in ADDR_W bits.
               lastAddr_d = ADDR_W'(rxDado - 8'd1);
               addr_d     = '0;
               idx_d      = '0;
               state_d    = ST_DADOS;
            end
         end
         ST_DADOS: begin
            if (rxFrameErr) begin
               state_d = ST_ERRO;
               erro_d  = 1'b1;
            end else if (rxByteValid) begin
               word_d[{idx_q, 3'b000} +: 8] = rxDado;
               if (idx_q == 2'(BYTES_PER_WORD - 1)) state_d = ST_ESCRITA;
               else                                 idx_d   = idx_q + 1'b1;
            end
         end
         ST_ESCRITA: begin
            if (addr_q == lastAddr_q) begin
               state_d     = ST_FIM;
               carregado_d = 1'b1;
            end else begin
               addr_d  = addr_q + 1'b1;
               idx_d   = '0;
               state_d = ST_DADOS;
            end
         end
         ST_FIM:  state_d = ST_FIM;
         ST_ERRO: state_d = ST_ERRO;
         default: state_d = ST_CONTA;
      endcase
      imemWe_d = (state_d == ST_ESCRITA);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_CONTA;
         addr_q      <= '0;
         lastAddr_q  <= '0;
         idx_q       <= '0;
         word_q      <= '0;
         imemWe_q    <= 1'b0;
         carregado_q <= 1'b0;
         erro_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         lastAddr_q  <= lastAddr_d;
         idx_q       <= idx_d;
         word_q      <= word_d;
         imemWe_q    <= imemWe_d;
         carregado_q <= carregado_d;
         erro_q      <= erro_d;
      end
   end

   assign imem_we    = imemWe_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = word_q;
   assign cpu_rst    = carregado_q;
   assign carregado  = carregado_q;
   assign erro       = erro_q;

endmodule
